// File: rtl/toggle_clk_meter.sv
// Measures the period of a slow asynchronous toggle clock in clk cycles and flags stalls.
// Optional glitch filter between synchronizer and edge detect: define GLITCH_FILT_EN.
module toggle_clk_meter #(
  parameter int CNT_W       = 27,
  parameter int TIMEOUT     = 100_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             enable,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_MEAS  = 2'd2,
    S_STALL = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1_C = CNT_W'(TIMEOUT - 1);

  if (SYNC_STAGES < 2 || FILT_LEN < 1 || TIMEOUT < 2 ||
      longint'(TIMEOUT) >= (longint'(1) << CNT_W)) begin : g_param_check
    $error("toggle_clk_meter: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl;
  logic                   lvl_prev_q, lvl_prev_d;
  logic                   rise;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   edge_pulse_q, edge_pulse_d;
  logic                   period_valid_q, period_valid_d;
  logic                   timeout_q, timeout_d;

  assign sync_d     = {sync_q[SYNC_STAGES-2:0], clk_in};
  assign lvl_prev_d = lvl;
  assign rise       = lvl & ~lvl_prev_q;

`ifdef GLITCH_FILT_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);

  logic [FC_W-1:0] filt_cnt_q, filt_cnt_d;
  logic            filt_lvl_q, filt_lvl_d;

  // The filtered level follows the synced input only after FILT_LEN consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    filt_lvl_d = filt_lvl_q;
    filt_cnt_d = '0;
    if (sync_q[SYNC_STAGES-1] != filt_lvl_q) begin
      if (filt_cnt_q == FC_W'(FILT_LEN - 1)) begin
        filt_lvl_d = sync_q[SYNC_STAGES-1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt_q <= '0;
      filt_lvl_q <= 1'b0;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      filt_lvl_q <= filt_lvl_d;
    end
  end

  assign lvl = filt_lvl_q;
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  // NOTE: reset is synchronous, so it lives inside the clocked branch; every
  // flop uses <= so all of them see pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q         <= '0;
      lvl_prev_q     <= 1'b0;
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      edge_pulse_q   <= 1'b0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      lvl_prev_q     <= lvl_prev_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      edge_pulse_q   <= edge_pulse_d;
      period_valid_q <= period_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  // Disable wins over everything; a rise wins over the timeout condition.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:        state_d = S_ARM;
        S_ARM, S_MEAS: begin
          if (rise)                       state_d = S_MEAS;
          else if (cnt_q == TIMEOUT_M1_C) state_d = S_STALL;
        end
        S_STALL:       if (rise) state_d = S_MEAS;
        default:       state_d = S_IDLE;
      endcase
    end
  end

  assign cnt_inc = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + 1'b1;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    edge_pulse_d   = rise;
    timeout_d      = (state_d == S_STALL);
    if (!enable) begin
      cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE:  cnt_d = '0;
        S_ARM:   cnt_d = rise ? CNT_W'(1) : cnt_inc;
        S_MEAS: begin
          if (rise) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            cnt_d          = CNT_W'(1);
          end else begin
            cnt_d = cnt_inc;
          end
        end
        // The stalled interval is discarded: restart counting without a report.
        S_STALL: if (rise) cnt_d = CNT_W'(1);
        default: cnt_d = '0;
      endcase
    end
  end

  assign edge_pulse   = edge_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign timeout      = timeout_q;
  assign state        = state_q;

endmodule
